mem_fill_responder: RTL and testbench
=====================================

Name: mem_fill_responder

Overview:
- Memory-side responder for the cache fill protocol.
- Accepts block-fill requests from the icache and dcache fill FSMs, plus single-word write-through requests from the dcache.
- Arbitrates between the two requesters and sequences word accesses to the shared multi-cycle main memory.
- Returns each word to the granted requester with a valid strobe and a word index.
- Sits between both caches and main memory, replacing the ad-hoc enable/address muxing at the CPU top level.

Parameters:
- WORDS, 8, words per cache block; power of two; block is 2*WORDS bytes.
- AW, 16, byte-address width.
- DW, 16, data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active high.
- i_req  in  1  icache fill request; held high by requester until i_busy rises.
- i_addr  in  AW  icache miss byte address.
- i_busy  out  1  icache burst in progress.
- i_valid  out  1  icache fill word strobe.
- i_word  out  log2(WORDS)  word offset of i_data within the block.
- i_data  out  DW  fill data; 0 when i_valid is low.
- i_done  out  1  pulse coincident with the final i_valid.
- d_req  in  1  dcache request (fill or write); held until d_busy rises or d_wr_ack pulses.
- d_wr  in  1  qualifies d_req as a single-word write.
- d_addr  in  AW  dcache byte address.
- d_wdata  in  DW  write data.
- d_busy  out  1  dcache fill burst in progress.
- d_valid  out  1  dcache fill word strobe.
- d_word  out  log2(WORDS)  word offset of d_data within the block.
- d_data  out  DW  fill data; 0 when d_valid is low.
- d_done  out  1  pulse coincident with the final d_valid.
- d_wr_ack  out  1  one-cycle pulse; write issued to memory.
- mem_addr  out  AW  memory byte address.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_din  out  DW  memory write data.
- mem_dout  in  DW  memory read data.
- mem_valid  in  1  memory read data valid; fixed pipelined latency.

Behaviour:
- Reset: state IDLE, counters 0, owner none. All outputs 0, including mem_addr and mem_din.
- States: IDLE, WRITE, ISSUE, DRAIN.
- IDLE arbitration, evaluated each cycle:
  - d_req has priority over i_req.
  - d_req & d_wr -> WRITE.
  - d_req & ~d_wr -> ISSUE, owner D.
  - else i_req -> ISSUE, owner I.
  - Latch base = addr[AW-1:log2(2*WORDS)] and the start word.
- WRITE, one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr with bit0 cleared, mem_din=d_wdata, d_wr_ack=1. Next state IDLE.
- ISSUE, WORDS cycles:
  - mem_en=1, mem_wr=0.
  - mem_addr = {base, issue_cnt, 1'b0}.
  - issue_cnt increments each cycle, wrapping modulo WORDS.
  - owner busy=1.
  - After the WORDS-th issue -> DRAIN.
- Returns, in ISSUE and DRAIN:
  - Each mem_valid drives owner valid=1, data=mem_dout, word=rcv_cnt; rcv_cnt then increments.
  - When the WORDS-th return arrives: owner done=1 that cycle, busy drops next cycle, state IDLE.
- Non-owner outputs stay 0 throughout a burst. The losing request stays pending and is granted at the next IDLE.
- Minimum one IDLE cycle between transactions. First mem_en of a burst occurs the cycle after the grant.
- mem_valid in IDLE or WRITE is ignored, with no strobes. This covers stale returns after reset.
- Reset mid-burst: abort immediately to IDLE. No done pulse. Counters cleared.
- Requests arriving while busy are not accepted until IDLE.
- Latency: memory returns are counted, not timed. Any fixed memory latency is supported.

Optional Feature:
- Macro: MEM_FILL_WRAP_EN. Selects critical-word-first wrap fill.
- Defined:
  - Issue and receive counters start at the requested word, addr[log2(2*WORDS)-1:1].
  - Both wrap modulo WORDS.
  - The word index reports the true block offset.
  - done still asserts after exactly WORDS returns.
- Undefined: both counters start at 0; the requested word offset is ignored.

Test Plan:
- I fill, i_req, i_addr=0x0236, 4-cycle memory -> mem_addr 0x0230,0x0232,...,0x023E on 8 consecutive cycles; 8 i_valid with i_word 0..7 carrying memory contents; i_done with i_word=7; d_* outputs stay 0.
- Simultaneous i_req and d_req (read, d_addr=0x1000) in IDLE -> D burst 0x1000..0x100E completes first; I burst starts the cycle after the IDLE following d_done.
- d_req & d_wr, d_addr=0x0045, d_wdata=0xBEEF while I burst active -> held until i_done; then WRITE cycle with mem_addr=0x0044, mem_wr=1, mem_din=0xBEEF, d_wr_ack=1.
- rst high during cycle 3 of ISSUE, then mem_valid pulses continue -> all outputs 0, no i_valid or i_done, state IDLE; next i_req yields a clean 8-word burst.
- mem_valid pulsed in IDLE with no request -> no valid strobe, no state change.
- MEM_FILL_WRAP_EN defined, i_addr=0x023A -> mem_addr 0x023A,0x023C,0x023E,0x0230,...,0x0238; i_word sequence 5,6,7,0,1,2,3,4; i_done with i_word=4.

Source files
------------

// File: rtl/mem_fill_responder.sv
// Memory-side responder: arbitrates icache/dcache fills and dcache write-through onto one pipelined memory.
// Define MEM_FILL_WRAP_EN for critical-word-first wrap fills; otherwise every burst starts at word 0.
module mem_fill_responder #(
    parameter int WORDS = 8,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [AW-1:0]              i_addr,
    output logic                       i_busy,
    output logic                       i_valid,
    output logic [$clog2(WORDS)-1:0]   i_word,
    output logic [DW-1:0]              i_data,
    output logic                       i_done,
    input  logic                       d_req,
    input  logic                       d_wr,
    input  logic [AW-1:0]              d_addr,
    input  logic [DW-1:0]              d_wdata,
    output logic                       d_busy,
    output logic                       d_valid,
    output logic [$clog2(WORDS)-1:0]   d_word,
    output logic [DW-1:0]              d_data,
    output logic                       d_done,
    output logic                       d_wr_ack,
    output logic [AW-1:0]              mem_addr,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [DW-1:0]              mem_din,
    input  logic [DW-1:0]              mem_dout,
    input  logic                       mem_valid
);

    localparam int WL  = $clog2(WORDS);
    localparam int OFF = WL + 1;
    localparam int BW  = AW - OFF;
    localparam logic [WL-1:0] LAST = WL'(WORDS - 1);
    localparam logic [WL-1:0] ONE  = WL'(1);

    typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic [WL-1:0]   iss_cnt_q, iss_cnt_d;
    logic [WL-1:0]   rcv_cnt_q, rcv_cnt_d;
    logic [WL-1:0]   iss_num_q, iss_num_d;
    logic [WL-1:0]   rcv_num_q, rcv_num_d;
    logic [BW-1:0]   base_q, base_d;
    logic [AW-2:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [AW-1:0]   req_addr;
    logic [WL-1:0]   start_word;
    logic            in_burst;
    logic            ret;
    logic            last_ret;
    logic            unused_addr_bits;

    assign req_addr = d_req ? d_addr : i_addr;
`ifdef MEM_FILL_WRAP_EN
    assign start_word = req_addr[OFF-1:1];
`else
    assign start_word = '0;
`endif
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    // Returns are counted, not timed, so any fixed memory latency works.
    assign in_burst = (state_q == ISSUE) || (state_q == DRAIN);
    assign ret      = in_burst && mem_valid;
    assign last_ret = ret && (rcv_num_q == LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        iss_cnt_d = iss_cnt_q;
        rcv_cnt_d = rcv_cnt_q;
        iss_num_d = iss_num_q;
        rcv_num_d = rcv_num_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (d_req && d_wr) begin
                    state_d   = WRITE;
                    wr_addr_d = d_addr[AW-1:1];
                    wr_data_d = d_wdata;
                end else if (d_req || i_req) begin
                    state_d   = ISSUE;
                    owner_d   = d_req ? OWN_D : OWN_I;
                    base_d    = req_addr[AW-1:OFF];
                    iss_cnt_d = start_word;
                    rcv_cnt_d = start_word;
                    iss_num_d = '0;
                    rcv_num_d = '0;
                end
            end
            WRITE: state_d = IDLE;
            ISSUE: begin
                iss_cnt_d = iss_cnt_q + ONE;
                iss_num_d = iss_num_q + ONE;
                if (iss_num_q == LAST) state_d = DRAIN;
            end
            default: ;
        endcase
        if (ret) begin
            rcv_cnt_d = rcv_cnt_q + ONE;
            rcv_num_d = rcv_num_q + ONE;
            if (last_ret) begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
            iss_num_q <= '0;
            rcv_num_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            iss_num_q <= iss_num_d;
            rcv_num_q <= rcv_num_d;
        end
    end

    always_ff @(posedge clk) begin
        base_q    <= base_d;
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
    end

    // Outputs are forced quiet while rst is high so an aborted burst emits nothing.
    always_comb begin
        i_busy   = 1'b0;
        i_valid  = 1'b0;
        i_word   = '0;
        i_data   = '0;
        i_done   = 1'b0;
        d_busy   = 1'b0;
        d_valid  = 1'b0;
        d_word   = '0;
        d_data   = '0;
        d_done   = 1'b0;
        d_wr_ack = 1'b0;
        mem_addr = '0;
        mem_en   = 1'b0;
        mem_wr   = 1'b0;
        mem_din  = '0;
        if (!rst) begin
            if (state_q == WRITE) begin
                mem_en   = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = {wr_addr_q, 1'b0};
                mem_din  = wr_data_q;
                d_wr_ack = 1'b1;
            end
            if (state_q == ISSUE) begin
                mem_en   = 1'b1;
                mem_addr = {base_q, iss_cnt_q, 1'b0};
            end
            if (in_burst && owner_q == OWN_I) begin
                i_busy  = 1'b1;
                i_valid = ret;
                i_word  = ret ? rcv_cnt_q : '0;
                i_data  = ret ? mem_dout : '0;
                i_done  = last_ret;
            end
            if (in_burst && owner_q == OWN_D) begin
                d_busy  = 1'b1;
                d_valid = ret;
                d_word  = ret ? rcv_cnt_q : '0;
                d_data  = ret ? mem_dout : '0;
                d_done  = last_ret;
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench for mem_fill_responder with a fixed-latency pipelined memory model.
module tb_mem_fill_responder;
    localparam int WORDS = 8;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic i_busy, i_valid, i_done, d_busy, d_valid, d_done, d_wr_ack;
    logic [2:0] i_word, d_word;
    logic [DW-1:0] i_data, d_data, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic mem_en, mem_wr, mem_valid;
    logic inj = 1'b0;

    mem_fill_responder #(.WORDS(WORDS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_valid(i_valid),
        .i_word(i_word), .i_data(i_data), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_busy(d_busy), .d_valid(d_valid), .d_word(d_word), .d_data(d_data),
        .d_done(d_done), .d_wr_ack(d_wr_ack),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_valid(mem_valid)
    );

    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Pipelined memory: every read issued returns LAT cycles later.
    logic [LAT-1:0] pv = '0;
    logic [AW-1:0]  pa [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
    assign mem_valid = pv[LAT-1] | inj;
    assign mem_dout  = pv[LAT-1] ? fdata(pa[LAT-1]) : (inj ? 16'h5A5A : 16'h0000);

    typedef struct { logic [AW-1:0] addr; logic wr; logic [DW-1:0] din; } mem_t;
    typedef struct { logic d; logic [2:0] word; logic [DW-1:0] data; logic done; } ret_t;
    mem_t exp_mem[$];
    ret_t exp_ret[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] start_of(input logic [AW-1:0] a);
`ifdef MEM_FILL_WRAP_EN
        return a[3:1];
`else
        return 3'd0;
`endif
    endfunction

    task automatic push_fill(input logic d, input logic [AW-1:0] a);
        logic [AW-1:0] base;
        logic [2:0] w;
        base = a & 16'hFFF0;
        for (int k = 0; k < WORDS; k++) begin
            w = start_of(a) + 3'(k);
            exp_mem.push_back('{base + {12'd0, w, 1'b0}, 1'b0, 16'h0});
            exp_ret.push_back('{d, w, fdata(base + {12'd0, w, 1'b0}), (k == WORDS - 1)});
        end
    endtask

    // Monitor: every DUT presentation is matched against the head of its queue.
    initial forever begin
        mem_t m;
        ret_t r;
        @(posedge clk);
        #1;
        if (mem_en) begin
            if (exp_mem.size() == 0) chk("mem_en_unexpected", {48'd0, mem_addr}, 64'hFFFF_FFFF);
            else begin
                m = exp_mem.pop_front();
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_wr", mem_wr, m.wr);
                chk("d_wr_ack", d_wr_ack, m.wr);
                if (m.wr) chk("mem_din", mem_din, m.din);
            end
        end else if (mem_wr || d_wr_ack) chk("wr_without_en", {mem_wr, d_wr_ack}, 2'b00);
        if (i_valid || d_valid) begin
            if (exp_ret.size() == 0) chk("strobe_unexpected", {d_valid, i_valid}, 2'b00);
            else begin
                r = exp_ret.pop_front();
                chk("ret_port", {d_valid, i_valid}, r.d ? 2'b10 : 2'b01);
                chk("ret_word", r.d ? d_word : i_word, r.word);
                chk("ret_data", r.d ? d_data : i_data, r.data);
                chk("ret_done", r.d ? d_done : i_done, r.done);
            end
        end
        if (!i_valid && (i_data != 0 || i_done)) chk("i_quiet", {i_done, i_data}, 0);
        if (!d_valid && (d_data != 0 || d_done)) chk("d_quiet", {d_done, d_data}, 0);
    end

    // Requesters hold their request until the responder acknowledges it.
    task automatic step();
        @(negedge clk);
        if (i_busy) i_req = 1'b0;
        if (d_busy || d_wr_ack) begin
            d_req = 1'b0;
            d_wr  = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while ((i_busy || d_busy || mem_en || exp_mem.size() != 0 || exp_ret.size() != 0) && n < 200);
        chk({name, "_timeout"}, (n < 200), 1'b1);
    endtask

    initial begin
        logic [AW-1:0] first;
        int n;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_outputs", {i_busy, i_valid, i_done, d_busy, d_valid, d_done, d_wr_ack,
                              mem_en, mem_wr, mem_addr, mem_din, i_data, d_data}, 0);

        // I fill at 0x0236
        push_fill(1'b0, 16'h0236);
        first = 16'h0230 + {12'd0, start_of(16'h0236), 1'b0};
        i_req = 1'b1; i_addr = 16'h0236;
        step();
        chk("t1_first_issue", {i_busy, d_busy, mem_en, mem_addr}, {1'b1, 1'b0, 1'b1, first});
        wait_quiet("t1");

        // simultaneous requests: D read wins
        push_fill(1'b1, 16'h1000);
        push_fill(1'b0, 16'h0410);
        i_req = 1'b1; i_addr = 16'h0410;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h1000;
        step();
        chk("t2_d_granted", {d_busy, i_busy}, 2'b10);
        n = 0;
        while (!d_done && n < 100) begin step(); n++; end
        chk("t2_d_done_seen", d_done, 1'b1);
        step();
        chk("t2_idle_gap", {i_busy, d_busy, mem_en}, 3'b000);
        step();
        chk("t2_i_start", {i_busy, mem_en, mem_addr}, {2'b11, 16'h0410});
        wait_quiet("t2");

        // write arriving during an I burst waits for i_done
        push_fill(1'b0, 16'h0300);
        exp_mem.push_back('{16'h0044, 1'b1, 16'hBEEF});
        i_req = 1'b1; i_addr = 16'h0300;
        step();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0045; d_wdata = 16'hBEEF;
        n = 0;
        while (!d_wr_ack && n < 100) begin step(); n++; end
        chk("t3_write_cycle", {d_wr_ack, mem_en, mem_wr, mem_addr, mem_din, i_busy},
            {3'b111, 16'h0044, 16'hBEEF, 1'b0});
        wait_quiet("t3");

        // reset during the third ISSUE cycle
        for (int k = 0; k < 3; k++) exp_mem.push_back('{16'h0100 + 16'(2 * k), 1'b0, 16'h0});
        i_req = 1'b1; i_addr = 16'h0100;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("t4_rst_outputs", {i_busy, i_valid, i_done, mem_en, mem_addr}, 0);
        step();
        rst = 1'b0;
        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (6) step();
        chk("t4_aborted", {i_busy, mem_en, 8'(exp_mem.size()), 8'(exp_ret.size())}, 0);
        push_fill(1'b0, 16'h0100);
        i_req = 1'b1; i_addr = 16'h0100;
        wait_quiet("t4");

        // stray mem_valid in IDLE
        inj = 1'b1;
        #1;
        chk("t5_no_strobe", {i_valid, d_valid, i_done, d_done}, 4'b0000);
        step();
        inj = 1'b0;
        chk("t5_still_idle", {i_busy, d_busy, mem_en}, 3'b000);

        // requested word 5 at 0x023A
        push_fill(1'b0, 16'h023A);
        i_req = 1'b1; i_addr = 16'h023A;
        step();
`ifdef MEM_FILL_WRAP_EN
        chk("t6_first_addr", mem_addr, 16'h023A);
`else
        chk("t6_first_addr", mem_addr, 16'h0230);
`endif
        wait_quiet("t6");

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
